// File: rtl/dda_state_tx.sv
// Lorenz DDA state framer: decimates solver steps, snapshots x/y/z and streams a sequence-numbered
// byte frame through the UART handshake. Define DDA_TX_CHECKSUM_EN to append an XOR checksum byte.
module dda_state_tx #(
    parameter int          N     = 16,
    parameter int          DECIM = 16,
    parameter logic [7:0]  SYNC  = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    input  logic         uart_busy,
    output logic         uart_transmit,
    output logic [7:0]   uart_tx_byte,
    output logic         frame_busy,
    output logic [7:0]   drop_count
);

`ifdef DDA_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
    localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          hold_q, hold_d;
    logic [47:0]   snap_q, snap_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    dec_q, dec_d;
    logic [7:0]    drop_q, drop_d;
    logic          tx_q, tx_d;
    logic [7:0]    byte_q, byte_d;
    logic          busy_q, busy_d;
    logic          due_s;

    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [7:0]  seq,
                                              input logic [47:0] snap);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SYNC;
            4'd1:    b = seq;
            4'd2:    b = snap[47:40];
            4'd3:    b = snap[39:32];
            4'd4:    b = snap[31:24];
            4'd5:    b = snap[23:16];
            4'd6:    b = snap[15:8];
            4'd7:    b = snap[7:0];
`ifdef DDA_TX_CHECKSUM_EN
            4'd8:    b = seq ^ snap[47:40] ^ snap[39:32] ^ snap[31:24]
                         ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state, decimator, drop counter and UART request logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        snap_d  = snap_q;
        seq_d   = seq_q;
        dec_d   = dec_q;
        drop_d  = drop_q;
        tx_d    = 1'b0;
        byte_d  = byte_q;
        due_s   = step_valid && (dec_q == DEC_LAST);

        if (step_valid) begin
            dec_d = due_s ? 8'd0 : dec_q + 8'd1;
        end else begin
            dec_d = dec_q;
        end

        // The cycle leaving WAIT for IDLE is still busy, so a capture there is dropped.
        if (due_s && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (due_s) begin
                    snap_d  = {x, y, z};
                    idx_d   = 4'd0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!uart_busy) begin
                    tx_d    = 1'b1;
                    byte_d  = frame_byte(idx_q, seq_q, snap_q);
                    hold_d  = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_HOLD: begin
                if (hold_q) begin
                    state_d = ST_WAIT;
                end else begin
                    hold_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!uart_busy) begin
                    if (idx_q == LAST_IDX) begin
                        seq_d   = seq_q + 8'd1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            hold_q  <= 1'b0;
            snap_q  <= 48'd0;
            seq_q   <= 8'd0;
            dec_q   <= 8'd0;
            drop_q  <= 8'd0;
            tx_q    <= 1'b0;
            byte_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            snap_q  <= snap_d;
            seq_q   <= seq_d;
            dec_q   <= dec_d;
            drop_q  <= drop_d;
            tx_q    <= tx_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_transmit = tx_q;
    assign uart_tx_byte  = byte_q;
    assign frame_busy    = busy_q;
    assign drop_count    = drop_q;

endmodule
